// File: rtl/debug_tx_fifo_pkg.sv
// Shared definitions for the debug transmit FIFO: drain FSM encodings and default depth.
// The FSM encodings sit here so the other debug peripheral blocks can use the same names.
package debug_tx_fifo_pkg;

   localparam int DEFAULT_DEPTH_LOG2 = 8;

   typedef enum logic [1:0] {
      s_TXF_IDLE      = 2'd0,
      s_TXF_LOAD      = 2'd1,
      s_TXF_SEND      = 2'd2,
      s_TXF_WAIT_DONE = 2'd3
   } txf_state_t;

endpackage

// File: rtl/debug_fifo_ram.sv
// Simple dual-port byte RAM with synchronous write and registered read.
// The read register updates only when a read is requested, so data holds between pops.
module debug_fifo_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              i_Clock,
   input  logic              i_Wr_En,
   input  logic [ADDR_W-1:0] i_Wr_Addr,
   input  logic [7:0]        i_Wr_Data,
   input  logic              i_Rd_En,
   input  logic [ADDR_W-1:0] i_Rd_Addr,
   output logic [7:0]        o_Rd_Data
);

   logic [7:0] mem_q [0:(1<<ADDR_W)-1];
   logic [7:0] rd_data_q;

   always_ff @(posedge i_Clock) begin
      if (i_Wr_En) begin
         mem_q[i_Wr_Addr] <= i_Wr_Data;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Rd_En) begin
         rd_data_q <= mem_q[i_Rd_Addr];
      end
   end

   assign o_Rd_Data = rd_data_q;

endmodule

// File: rtl/debug_tx_fifo.sv
// Byte FIFO between debug command logic and the UART transmitter, with a drain FSM
// that pops queued bytes in order and runs the transmitter's DV/Done handshake.
module debug_tx_fifo
   import debug_tx_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset_N,
   input  logic                  i_Wr_DV,
   input  logic [7:0]            i_Wr_Byte,
   input  logic                  i_Flush,
   input  logic                  i_Drain_En,
   input  logic                  i_Clear_Overflow,
   output logic                  o_Full,
   output logic                  o_Empty,
   output logic [DEPTH_LOG2:0]   o_Count,
   output logic                  o_Overflow,
   output logic                  o_Busy,
   output logic                  o_Tx_DV,
   output logic [7:0]            o_Tx_Byte,
   input  logic                  i_Tx_Done
);

   localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   txf_state_t            state_q, state_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  tx_dv_q, tx_dv_d;
   logic [7:0]            tx_byte_q, tx_byte_d;

   logic                  full;
   logic                  empty;
   logic                  push_ok;
   logic                  push_drop;
   logic                  pop;
   logic [7:0]            ram_rd_data;

   // Full/empty come from the registered count, so nothing on the push side reaches an output.
   assign full      = (count_q == FULL_COUNT);
   assign empty     = (count_q == '0);
   assign push_ok   = i_Wr_DV & ~full & ~i_Flush;
   assign push_drop = i_Wr_DV &  full & ~i_Flush;
   assign pop       = (state_q == s_TXF_IDLE) & ~empty & i_Drain_En & ~i_Flush;

   debug_fifo_ram #(
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .i_Clock   (i_Clock),
      .i_Wr_En   (push_ok),
      .i_Wr_Addr (wr_ptr_q),
      .i_Wr_Data (i_Wr_Byte),
      .i_Rd_En   (pop),
      .i_Rd_Addr (rd_ptr_q),
      .o_Rd_Data (ram_rd_data)
   );

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (i_Flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end

      // A dropped push outranks a same-cycle clear so no overflow event is lost.
      if (push_drop) begin
         overflow_d = 1'b1;
      end else if (i_Clear_Overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      tx_dv_d   = 1'b0;
      tx_byte_d = tx_byte_q;

      case (state_q)
         s_TXF_IDLE: begin
            if (pop) begin
               state_d = s_TXF_LOAD;
            end
         end
         s_TXF_LOAD: begin
            tx_byte_d = ram_rd_data;
            tx_dv_d   = 1'b1;
            state_d   = s_TXF_SEND;
         end
         s_TXF_SEND: begin
            state_d = s_TXF_WAIT_DONE;
         end
         s_TXF_WAIT_DONE: begin
            if (i_Tx_Done) begin
               state_d = s_TXF_IDLE;
            end
         end
         default: begin
            state_d = s_TXF_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_N) begin
         state_q    <= s_TXF_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         tx_dv_q    <= 1'b0;
         tx_byte_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         tx_dv_q    <= tx_dv_d;
         tx_byte_q  <= tx_byte_d;
      end
   end

   assign o_Full     = full;
   assign o_Empty    = empty;
   assign o_Count    = count_q;
   assign o_Overflow = overflow_q;
   assign o_Busy     = (state_q != s_TXF_IDLE);
   assign o_Tx_DV    = tx_dv_q;
   assign o_Tx_Byte  = tx_byte_q;

endmodule

// File: tb/tb_debug_tx_fifo.sv
// Self-checking bench for debug_tx_fifo: a 256-entry and an 8-entry instance share stimulus,
// each with its own transmitter model returning Done a fixed number of cycles after DV.
module tb_debug_tx_fifo;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       wr_dv = 1'b0;
   logic [7:0] wr_byte = 8'h00;
   logic       flush = 1'b0;
   logic       drain_en = 1'b0;
   logic       clr_ovf = 1'b0;

   logic       b_full, b_empty, b_ovf, b_busy, b_tx_dv;
   logic [8:0] b_count;
   logic [7:0] b_tx_byte;
   logic       b_tx_done = 1'b0;

   logic       s_full, s_empty, s_ovf, s_busy, s_tx_dv;
   logic [3:0] s_count;
   logic [7:0] s_tx_byte;
   logic       s_tx_done = 1'b0;

   debug_tx_fifo #(.DEPTH_LOG2(8)) dut_big (
      .i_Clock (clk), .i_Reset_N (rst_n), .i_Wr_DV (wr_dv), .i_Wr_Byte (wr_byte),
      .i_Flush (flush), .i_Drain_En (drain_en), .i_Clear_Overflow (clr_ovf),
      .o_Full (b_full), .o_Empty (b_empty), .o_Count (b_count), .o_Overflow (b_ovf),
      .o_Busy (b_busy), .o_Tx_DV (b_tx_dv), .o_Tx_Byte (b_tx_byte), .i_Tx_Done (b_tx_done)
   );

   debug_tx_fifo #(.DEPTH_LOG2(3)) dut_small (
      .i_Clock (clk), .i_Reset_N (rst_n), .i_Wr_DV (wr_dv), .i_Wr_Byte (wr_byte),
      .i_Flush (flush), .i_Drain_En (drain_en), .i_Clear_Overflow (clr_ovf),
      .o_Full (s_full), .o_Empty (s_empty), .o_Count (s_count), .o_Overflow (s_ovf),
      .o_Busy (s_busy), .o_Tx_DV (s_tx_dv), .o_Tx_Byte (s_tx_byte), .i_Tx_Done (s_tx_done)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int done_delay = 5;

   // Transmitter models: record every DV byte and the edge at which Done is sampled.
   logic [7:0] b_bytes[$];
   int         b_dv_cyc[$];
   int         b_done_edge[$];
   int         b_wide = 0;
   int         b_cnt = 0;
   logic       b_prev_dv = 1'b0;

   always @(negedge clk) begin
      b_tx_done = 1'b0;
      if (!rst_n) b_cnt = 0;
      else if (b_cnt > 0) begin
         b_cnt--;
         if (b_cnt == 0) begin
            b_tx_done = 1'b1;
            b_done_edge.push_back(cyc + 1);
         end
      end
      if (b_tx_dv === 1'b1) begin
         b_bytes.push_back(b_tx_byte);
         b_dv_cyc.push_back(cyc);
         if (b_prev_dv) b_wide++;
         if (rst_n) b_cnt = done_delay;
      end
      b_prev_dv = (b_tx_dv === 1'b1);
   end

   logic [7:0] s_bytes[$];
   int         s_wide = 0;
   int         s_cnt = 0;
   logic       s_prev_dv = 1'b0;

   always @(negedge clk) begin
      s_tx_done = 1'b0;
      if (!rst_n) s_cnt = 0;
      else if (s_cnt > 0) begin
         s_cnt--;
         if (s_cnt == 0) s_tx_done = 1'b1;
      end
      if (s_tx_dv === 1'b1) begin
         s_bytes.push_back(s_tx_byte);
         if (s_prev_dv) s_wide++;
         if (rst_n) s_cnt = done_delay;
      end
      s_prev_dv = (s_tx_dv === 1'b1);
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wr_dv = 1'b0; wr_byte = 8'h00; flush = 1'b0;
      drain_en = 1'b0; clr_ovf = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic check_big_idle(input string p);
      check({p, "_b_full"}, b_full, 0);
      check({p, "_b_empty"}, b_empty, 1);
      check({p, "_b_count"}, b_count, 0);
      check({p, "_b_ovf"}, b_ovf, 0);
      check({p, "_b_busy"}, b_busy, 0);
      check({p, "_b_txdv"}, b_tx_dv, 0);
      check({p, "_b_txbyte"}, b_tx_byte, 0);
   endtask

   task automatic check_small_idle(input string p);
      check({p, "_s_full"}, s_full, 0);
      check({p, "_s_empty"}, s_empty, 1);
      check({p, "_s_count"}, s_count, 0);
      check({p, "_s_ovf"}, s_ovf, 0);
      check({p, "_s_busy"}, s_busy, 0);
      check({p, "_s_txdv"}, s_tx_dv, 0);
   endtask

   typedef struct {
      logic       wr;
      logic [7:0] data;
      logic       clr;
      logic       full;
      logic       empty;
      logic [3:0] count;
      logic       ovf;
   } vec_t;

   vec_t vecs[12];
   int   max_cnt;

   task automatic step_track(input int n = 1);
      repeat (n) begin
         step();
         if (int'(s_count) > max_cnt) max_cnt = int'(s_count);
      end
   endtask

   initial begin
      int  base, dbase, sbase, wbase;
      logic ok, busy_ok, empty_ok;

      // Small-FIFO fill table, drain held off: 8 pushes fill, then drops and overflow clearing.
      for (int i = 0; i < 8; i++)
         vecs[i] = '{1'b1, 8'(8'h10 + i), 1'b0, (i == 7), 1'b0, 4'(i + 1), 1'b0};
      vecs[8]  = '{1'b1, 8'h18, 1'b0, 1'b1, 1'b0, 4'd8, 1'b1};
      vecs[9]  = '{1'b1, 8'h19, 1'b1, 1'b1, 1'b0, 4'd8, 1'b1};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd8, 1'b0};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0};

      // Reset state
      do_reset();
      check_big_idle("rst");
      check_small_idle("rst");

      // Single byte latency
      $display("test: single byte");
      do_reset();
      base = b_bytes.size();
      drain_en = 1'b1; done_delay = 5;
      wr_dv = 1'b1; wr_byte = 8'hA5;
      step();
      wr_dv = 1'b0;
      check("t1_empty_e0", b_empty, 0);
      step();
      check("t1_busy_load", b_busy, 1);
      check("t1_empty_load", b_empty, 1);
      check("t1_dv_e1", b_tx_dv, 0);
      step();
      check("t1_dv_e2", b_tx_dv, 1);
      check("t1_byte", b_tx_byte, 8'hA5);
      step();
      check("t1_dv_e3", b_tx_dv, 0);
      ok = 1'b0; busy_ok = 1'b1; empty_ok = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         step();
         if (b_tx_done) ok = 1'b1;
         else if (!b_busy) busy_ok = 1'b0;
         if (!b_empty) empty_ok = 1'b0;
      end
      check("t1_done_seen", ok, 1);
      check("t1_busy_until_done", busy_ok, 1);
      check("t1_idle_after_done", b_busy, 0);
      check("t1_empty_throughout", empty_ok, 1);
      check("t1_dv_count", b_bytes.size() - base, 1);

      // Burst order and inter-byte spacing
      $display("test: burst of 16");
      do_reset();
      base = b_bytes.size(); dbase = b_done_edge.size(); wbase = b_wide;
      drain_en = 1'b1; done_delay = 20;
      for (int i = 0; i < 16; i++) begin
         wr_dv = 1'b1; wr_byte = 8'(i + 1);
         step();
      end
      wr_dv = 1'b0;
      for (int i = 0; i < 1000 && b_bytes.size() < base + 16; i++) step();
      step(40);
      check("t2_dv_count", b_bytes.size() - base, 16);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("t2_byte%0d", k), b_bytes[base + k], 8'(k + 1));
         $display("burst byte %0d: %02h", k, b_bytes[base + k]);
         if (k > 0)
            check($sformatf("t2_gap%0d", k), b_dv_cyc[base + k] - b_done_edge[dbase + k - 1], 2);
      end
      check("t2_single_cycle_dv", b_wide - wbase, 0);
      check("t2_idle_end", b_busy, 0);

      // Full / overflow on the 8-entry instance
      $display("test: full and overflow");
      do_reset();
      sbase = s_bytes.size();
      drain_en = 1'b0;
      for (int i = 0; i < 12; i++) begin
         wr_dv = vecs[i].wr; wr_byte = vecs[i].data; clr_ovf = vecs[i].clr;
         step();
         wr_dv = 1'b0; clr_ovf = 1'b0;
         check($sformatf("v%0d_full", i), s_full, vecs[i].full);
         check($sformatf("v%0d_empty", i), s_empty, vecs[i].empty);
         check($sformatf("v%0d_count", i), s_count, vecs[i].count);
         check($sformatf("v%0d_ovf", i), s_ovf, vecs[i].ovf);
         check($sformatf("v%0d_busy", i), s_busy, 0);
         $display("vec %0d: wr=%0d data=%02h count=%0d ovf=%0d", i, vecs[i].wr, vecs[i].data, s_count, s_ovf);
      end
      drain_en = 1'b1; done_delay = 3;
      for (int i = 0; i < 300 && s_bytes.size() < sbase + 8; i++) step();
      step(30);
      check("t3_dv_count", s_bytes.size() - sbase, 8);
      for (int k = 0; k < 8; k++)
         check($sformatf("t3_byte%0d", k), s_bytes[sbase + k], 8'(8'h10 + k));
      check("t3_count_end", s_count, 0);
      check("t3_empty_end", s_empty, 1);

      // Sustained push while draining across pointer wrap
      $display("test: wrap");
      do_reset();
      sbase = s_bytes.size(); wbase = s_wide;
      drain_en = 1'b1; done_delay = 1; max_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         wr_dv = 1'b1; wr_byte = 8'(8'h30 + k * 7);
         step_track();
         wr_dv = 1'b0;
         if (k >= 5) step_track((k % 2 != 0) ? 2 : 4);
      end
      for (int i = 0; i < 300 && s_bytes.size() < sbase + 20; i++) step_track();
      step_track(20);
      check("t4_dv_count", s_bytes.size() - sbase, 20);
      for (int k = 0; k < 20; k++)
         check($sformatf("t4_byte%0d", k), s_bytes[sbase + k], 8'(8'h30 + k * 7));
      check("t4_max_count_le8", (max_cnt <= 8), 1);
      check("t4_no_ovf", s_ovf, 0);
      check("t4_single_cycle_dv", s_wide - wbase, 0);

      // Flush while a byte waits for Done, with a same-cycle push
      $display("test: flush mid-transmission");
      do_reset();
      base = b_bytes.size();
      drain_en = 1'b1; done_delay = 10;
      wr_dv = 1'b1; wr_byte = 8'h11; step();
      wr_byte = 8'h22; step();
      wr_byte = 8'h33; step();
      wr_dv = 1'b0;
      step();
      check("t5_busy_wait", b_busy, 1);
      check("t5_count_before", b_count, 2);
      flush = 1'b1; wr_dv = 1'b1; wr_byte = 8'h44;
      step();
      flush = 1'b0; wr_dv = 1'b0;
      check("t5_count_after", b_count, 0);
      check("t5_empty_after", b_empty, 1);
      check("t5_ovf_after", b_ovf, 0);
      check("t5_still_busy", b_busy, 1);
      step(60);
      check("t5_dv_count", b_bytes.size() - base, 1);
      check("t5_byte", b_bytes[base], 8'h11);
      check("t5_idle_end", b_busy, 0);

      // Reset during SEND with bytes queued
      $display("test: reset mid-operation");
      do_reset();
      drain_en = 1'b0; done_delay = 10;
      for (int i = 0; i < 5; i++) begin
         wr_dv = 1'b1; wr_byte = 8'(8'h51 + i);
         step();
      end
      wr_dv = 1'b0;
      base = b_bytes.size();
      drain_en = 1'b1;
      step(2);
      check("t6_dv_send", b_tx_dv, 1);
      check("t6_count_send", b_count, 4);
      rst_n = 1'b0;
      step();
      check_big_idle("t6");
      rst_n = 1'b1;
      step(40);
      check("t6_no_dv_after", b_bytes.size() - base, 1);
      wr_dv = 1'b1; wr_byte = 8'h66;
      step();
      wr_dv = 1'b0;
      for (int i = 0; i < 60 && b_bytes.size() < base + 2; i++) step();
      check("t6_new_dv", b_bytes.size() - base, 2);
      check("t6_new_byte", b_bytes[base + 1], 8'h66);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
